// File: rtl/add_chk_pkg.sv
// Shared types and helpers for the adder stimulus/response checker:
// FSM states, the Galois LFSR step and the fixed corner-vector table.
package add_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } chk_state_e;

  // Right-shifting Galois form of the x^32+x^22+x^2+x+1 polynomial
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? LFSR_TAPS : 32'h0);
  endfunction

  // Returns {a, b}, each right-aligned in a 32-bit half and masked to width.
  function automatic logic [63:0] corner_pair(input logic [1:0] idx, input int unsigned width);
    logic [31:0] m;
    m = (width >= 32) ? 32'hFFFF_FFFF : ((32'h1 << width) - 32'h1);
    case (idx)
      2'd0:    return 64'h0;
      2'd1:    return {m, 32'h1};
      2'd2:    return {m, m};
      default: return {32'hAAAA_AAAA & m, 32'h5555_5555 & m};
    endcase
  endfunction

endpackage

// File: rtl/lfsr32.sv
// 32-bit Galois LFSR with seed load and advance enable; load+advance
// together yields the state one step past the seed.
module lfsr32
  import add_chk_pkg::*;
#(
  parameter logic [31:0] SEED = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        advance,
  output logic [31:0] state
);

  logic [31:0] state_q;
  logic [31:0] state_d;

  always_comb begin
    state_d = state_q;
    if (load && advance) begin
      state_d = lfsr_step(SEED);
    end else if (load) begin
      state_d = SEED;
    end else if (advance) begin
      state_d = lfsr_step(state_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/adder_stim_checker.sv
// In-fabric stimulus generator and golden-sum checker for a pipelined adder.
// Define ADD_CHK_CORNER_EN to make vectors 0..3 fixed corner cases.
module adder_stim_checker
  import add_chk_pkg::*;
#(
  parameter int          WIDTH       = 16,
  parameter int          LATENCY     = 1,
  parameter int          NUM_VECTORS = 1000000,
  parameter int          CNT_W       = 20,
  parameter logic [31:0] SEED_A      = 32'hACE1_0001,
  parameter logic [31:0] SEED_B      = 32'h1234_5678
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  input  logic [WIDTH:0]   dut_sum,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [WIDTH:0]   first_err_exp,
  output logic [WIDTH:0]   first_err_got
);

  localparam int PIPE = LATENCY + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VECTORS - 1);

  chk_state_e       state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic [CNT_W-1:0] launch_idx_q, launch_idx_d;
  logic [CNT_W-1:0] vec_count_q, vec_count_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic [CNT_W-1:0] first_err_idx_q, first_err_idx_d;
  logic [WIDTH:0]   first_err_exp_q, first_err_exp_d;
  logic [WIDTH:0]   first_err_got_q, first_err_got_d;

  logic [WIDTH:0]   pipe_sum_q [PIPE];
  logic [WIDTH:0]   pipe_sum_d [PIPE];
  logic             pipe_vld_q [PIPE];
  logic             pipe_vld_d [PIPE];

  logic             launch, lfsr_load, lfsr_adv;
  logic [CNT_W-1:0] lidx;
  logic [31:0]      lfsr_a_state, lfsr_b_state, src_a, src_b;
  logic [WIDTH-1:0] vec_a, vec_b;
  logic [63:0]      cp;
  logic [WIDTH:0]   head_sum;
  logic             head_vld;
  logic             tail_vld, mismatch;
  logic             unused_bits;

  lfsr32 #(.SEED(SEED_A)) u_lfsr_a (
    .clk     (clk),
    .rst     (rst),
    .load    (lfsr_load),
    .advance (lfsr_adv),
    .state   (lfsr_a_state)
  );

  lfsr32 #(.SEED(SEED_B)) u_lfsr_b (
    .clk     (clk),
    .rst     (rst),
    .load    (lfsr_load),
    .advance (lfsr_adv),
    .state   (lfsr_b_state)
  );

  assign tail_vld = pipe_vld_q[LATENCY];
  assign mismatch = tail_vld && (dut_sum != pipe_sum_q[LATENCY]);

  always_comb begin
    state_d         = state_q;
    op_a_d          = op_a_q;
    op_b_d          = op_b_q;
    launch_idx_d    = launch_idx_q;
    vec_count_d     = vec_count_q;
    err_count_d     = err_count_q;
    first_err_idx_d = first_err_idx_q;
    first_err_exp_d = first_err_exp_q;
    first_err_got_d = first_err_got_q;
    launch          = 1'b0;
    lfsr_load       = 1'b0;
    lidx            = launch_idx_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          launch          = 1'b1;
          lfsr_load       = 1'b1;
          lidx            = '0;
          launch_idx_d    = CNT_W'(1);
          vec_count_d     = '0;
          err_count_d     = '0;
          first_err_idx_d = '0;
          first_err_exp_d = '0;
          first_err_got_d = '0;
          state_d         = (NUM_VECTORS == 1) ? ST_DRAIN : ST_RUN;
        end
      end
      ST_RUN: begin
        launch       = 1'b1;
        launch_idx_d = launch_idx_q + CNT_W'(1);
        if (launch_idx_q == LAST_IDX) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (tail_vld && (vec_count_q == LAST_IDX)) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Vector 0 is launched on the same edge the seeds load, so use the seed directly
    src_a    = lfsr_load ? SEED_A : lfsr_a_state;
    src_b    = lfsr_load ? SEED_B : lfsr_b_state;
    vec_a    = src_a[WIDTH-1:0];
    vec_b    = src_b[WIDTH-1:0];
    lfsr_adv = launch;
    cp       = '0;
`ifdef ADD_CHK_CORNER_EN
    if (lidx < CNT_W'(4)) begin
      cp       = corner_pair(lidx[1:0], WIDTH);
      vec_a    = cp[32 +: WIDTH];
      vec_b    = cp[0 +: WIDTH];
      lfsr_adv = 1'b0;
    end
`endif
    head_vld = launch;
    head_sum = {1'b0, vec_a} + {1'b0, vec_b};
    if (launch) begin
      op_a_d = vec_a;
      op_b_d = vec_b;
    end

    if (tail_vld) begin
      vec_count_d = vec_count_q + CNT_W'(1);
      if (mismatch) begin
        if (err_count_q != '1) err_count_d = err_count_q + CNT_W'(1);
        if (err_count_q == '0) begin
          first_err_idx_d = vec_count_q;
          first_err_exp_d = pipe_sum_q[LATENCY];
          first_err_got_d = dut_sum;
        end
      end
    end
  end

  for (genvar gi = 0; gi < PIPE; gi++) begin : g_pipe
    if (gi == 0) begin : g_head
      assign pipe_sum_d[gi] = head_sum;
      assign pipe_vld_d[gi] = head_vld;
    end else begin : g_shift
      assign pipe_sum_d[gi] = pipe_sum_q[gi-1];
      assign pipe_vld_d[gi] = pipe_vld_q[gi-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      op_a_q          <= '0;
      op_b_q          <= '0;
      launch_idx_q    <= '0;
      vec_count_q     <= '0;
      err_count_q     <= '0;
      first_err_idx_q <= '0;
      first_err_exp_q <= '0;
      first_err_got_q <= '0;
      for (int k = 0; k < PIPE; k++) begin
        pipe_sum_q[k] <= '0;
        pipe_vld_q[k] <= 1'b0;
      end
    end else begin
      state_q         <= state_d;
      op_a_q          <= op_a_d;
      op_b_q          <= op_b_d;
      launch_idx_q    <= launch_idx_d;
      vec_count_q     <= vec_count_d;
      err_count_q     <= err_count_d;
      first_err_idx_q <= first_err_idx_d;
      first_err_exp_q <= first_err_exp_d;
      first_err_got_q <= first_err_got_d;
      for (int k = 0; k < PIPE; k++) begin
        pipe_sum_q[k] <= pipe_sum_d[k];
        pipe_vld_q[k] <= pipe_vld_d[k];
      end
    end
  end

  assign unused_bits   = ^{src_a, src_b, cp, lidx};

  assign op_a          = op_a_q;
  assign op_b          = op_b_q;
  assign busy          = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done          = (state_q == ST_DONE);
  assign pass          = done && (err_count_q == '0);
  assign vec_count     = vec_count_q;
  assign err_count     = err_count_q;
  assign first_err_idx = first_err_idx_q;
  assign first_err_exp = first_err_exp_q;
  assign first_err_got = first_err_got_q;

endmodule

// File: tb/tb_adder_stim_checker.sv
// Scoreboard bench: two checker instances (LATENCY 1 and 3) driving behavioural adder models.
module tb_adder_stim_checker;

  localparam int          W  = 16;
  localparam int          NV = 8;
  localparam int          CW = 20;
  localparam logic [31:0] SA = 32'hACE1_0001;
  localparam logic [31:0] SB = 32'h1234_5678;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start_a, start_b;
  logic [W-1:0]  op_a_a, op_b_a, op_a_b, op_b_b;
  logic [W:0]    dut_sum_a, dut_sum_b;
  logic          busy_a, done_a, pass_a, busy_b, done_b, pass_b;
  logic [CW-1:0] vec_a, err_a, fidx_a, vec_b, err_b, fidx_b;
  logic [W:0]    fexp_a, fgot_a, fexp_b, fgot_b;

  adder_stim_checker #(.WIDTH(W), .LATENCY(1), .NUM_VECTORS(NV), .CNT_W(CW),
                       .SEED_A(SA), .SEED_B(SB)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .op_a(op_a_a), .op_b(op_b_a),
    .dut_sum(dut_sum_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .vec_count(vec_a), .err_count(err_a), .first_err_idx(fidx_a),
    .first_err_exp(fexp_a), .first_err_got(fgot_a)
  );

  adder_stim_checker #(.WIDTH(W), .LATENCY(3), .NUM_VECTORS(NV), .CNT_W(CW),
                       .SEED_A(SA), .SEED_B(SB)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .op_a(op_a_b), .op_b(op_b_b),
    .dut_sum(dut_sum_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .vec_count(vec_b), .err_count(err_b), .first_err_idx(fidx_b),
    .first_err_exp(fexp_b), .first_err_got(fgot_b)
  );

  // Behavioural adders: one register for A (optionally bit 3 stuck at 0), 3 or 2 stages for B
  bit         force3  = 1'b0;
  int         depth_b = 3;
  logic [W:0] sum_a_r, sb0, sb1, sb2;

  always_ff @(posedge clk) begin
    sum_a_r <= {1'b0, op_a_a} + {1'b0, op_b_a};
    sb0     <= {1'b0, op_a_b} + {1'b0, op_b_b};
    sb1     <= sb0;
    sb2     <= sb1;
  end

  assign dut_sum_a = force3 ? (sum_a_r & ~17'h00008) : sum_a_r;
  assign dut_sum_b = (depth_b == 2) ? sb1 : sb2;

  int            cur = 0;
  logic [W-1:0]  o_opa, o_opb;
  logic          o_busy, o_done, o_pass;
  logic [CW-1:0] o_vec, o_err, o_fidx;
  logic [W:0]    o_fexp, o_fgot;

  always_comb begin
    o_opa = op_a_a; o_opb = op_b_a; o_busy = busy_a; o_done = done_a; o_pass = pass_a;
    o_vec = vec_a;  o_err = err_a;  o_fidx = fidx_a; o_fexp = fexp_a; o_fgot = fgot_a;
    if (cur != 0) begin
      o_opa = op_a_b; o_opb = op_b_b; o_busy = busy_b; o_done = done_b; o_pass = pass_b;
      o_vec = vec_b;  o_err = err_b;  o_fidx = fidx_b; o_fexp = fexp_b; o_fgot = fgot_b;
    end
  end

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [W-1:0] exp_a_q[$];
  logic [W-1:0] exp_b_q[$];
  logic [W:0]   sums[NV];
  logic [W-1:0] last_a;

  function automatic logic [31:0] step(input logic [31:0] s);
    logic [31:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ 32'h8020_0003;
    return r;
  endfunction

  task automatic push_vectors();
    logic [31:0]  sa, sb;
    logic [W-1:0] a, b;
    sa = SA;
    sb = SB;
    exp_a_q.delete();
    exp_b_q.delete();
    for (int i = 0; i < NV; i++) begin
      a = sa[W-1:0];
      b = sb[W-1:0];
`ifdef ADD_CHK_CORNER_EN
      case (i)
        0: begin a = 16'h0000; b = 16'h0000; end
        1: begin a = 16'hFFFF; b = 16'h0001; end
        2: begin a = 16'hFFFF; b = 16'hFFFF; end
        3: begin a = 16'hAAAA; b = 16'h5555; end
        default: begin sa = step(sa); sb = step(sb); end
      endcase
`else
      sa = step(sa);
      sb = step(sb);
`endif
      exp_a_q.push_back(a);
      exp_b_q.push_back(b);
      sums[i] = {1'b0, a} + {1'b0, b};
      last_a  = a;
    end
  endtask

  // mode 0: ideal model, 1: bit 3 of sum cleared (A), 2: model one stage short (B)
  task automatic run_test(input int sel, input int mode, input bit hold);
    int           edges, lat, errs, fi;
    logic [W-1:0] ea, eb;
    logic [W:0]   fgot;
    cur     = sel;
    lat     = (sel == 0) ? 1 : 3;
    force3  = (mode == 1);
    depth_b = (mode == 2) ? 2 : 3;
    push_vectors();
    if (sel == 0) start_a = 1'b1; else start_b = 1'b1;
    @(posedge clk); #1;
    if (!hold) begin start_a = 1'b0; start_b = 1'b0; end
    chk("busy_at_e0", o_busy, 1);
    chk("vec_clear_at_e0", o_vec, 0);
    edges = 0;
    while (!o_done && edges < 64) begin
      if (exp_a_q.size() > 0) begin
        ea = exp_a_q.pop_front();
        eb = exp_b_q.pop_front();
        $display("dut%0d vec %0d a=%h b=%h exp_a=%h exp_b=%h", sel, edges, o_opa, o_opb, ea, eb);
        chk("op_a", o_opa, ea);
        chk("op_b", o_opb, eb);
      end
      @(posedge clk); #1;
      edges++;
    end
    start_a = 1'b0;
    start_b = 1'b0;
    chk("done_edge", edges, NV + lat);

    errs = 0; fi = -1; fgot = '0;
    for (int i = 0; i < NV; i++) begin
      if (mode == 1 && sums[i][3]) begin
        errs++;
        if (fi < 0) begin fi = i; fgot = sums[i] & ~17'h00008; end
      end
      if (mode == 2 && i < NV - 1 && sums[i] != sums[i+1]) begin
        errs++;
        if (fi < 0) begin fi = i; fgot = sums[i+1]; end
      end
    end
    $display("dut%0d mode %0d run: vec=%0d err=%0d pass=%0b edges=%0d", sel, mode, o_vec, o_err, o_pass, edges);
    chk("vec_count", o_vec, NV);
    chk("err_count", o_err, errs);
    chk("pass", o_pass, (errs == 0));
    chk("busy_done", o_busy, 0);
    chk("op_hold", o_opa, last_a);
    if (mode != 0) chk("err_nonzero", (o_err != 0), 1);
    if (fi >= 0) begin
      chk("first_err_idx", o_fidx, fi);
      chk("first_err_exp", o_fexp, sums[fi]);
      chk("first_err_got", o_fgot, fgot);
    end else begin
      chk("first_err_idx_zero", o_fidx, 0);
    end
    @(posedge clk); #1;
    chk("done_stays", o_done, 1);
    chk("vec_stays", o_vec, NV);
  endtask

  task automatic run_abort();
    cur    = 0;
    force3 = 1'b1;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    $display("abort at vec 5: op_a=%h vec=%0d err=%0d", op_a_a, vec_a, err_a);
    chk("pre_abort_busy", busy_a, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", busy_a, 0);
    chk("abort_vec", vec_a, 0);
    chk("abort_err", err_a, 0);
    chk("abort_fidx", fidx_a, 0);
    chk("abort_op_a", op_a_a, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_op_a", op_a_a, 0);
    chk("rst_op_b", op_b_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_pass", pass_a, 0);
    chk("rst_vec", vec_a, 0);
    chk("rst_err", err_a, 0);
    @(posedge clk); #1;

    run_test(0, 0, 1'b0);
    run_test(0, 0, 1'b1);
    run_test(0, 0, 1'b0);
    run_test(0, 1, 1'b0);
    run_abort();
    run_test(0, 0, 1'b0);
    run_test(1, 0, 1'b0);
    run_test(1, 2, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/adder_stim_checker.md
# adder_stim_checker

Self-checking stimulus/response stage for the carry-skip adder family. Generates one operand pair per clock from two 32-bit LFSRs, drives the adder under test, delays a golden sum by the adder's pipeline depth, and compares it against the returned sum. It reports vector and error counts plus the first failing vector, which replaces file-based stimulus and dump comparison with an in-fabric pass/fail.

## Interface
- `WIDTH`, 16: operand width, 1..32.
- `LATENCY`, 1: number of register stages inside the adder under test, 0..8.
- `NUM_VECTORS`, 1000000: vectors per run, ≥1.
- `CNT_W`, 20: counter width; must satisfy 2^CNT_W > NUM_VECTORS.
- `SEED_A`, 32'hACE1_0001: LFSR A seed, nonzero.
- `SEED_B`, 32'h1234_5678: LFSR B seed, nonzero.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a run; sampled in IDLE or DONE.
- `op_a` out WIDTH: operand a to the adder.
- `op_b` out WIDTH: operand b to the adder.
- `dut_sum` in WIDTH+1: adder result, with carry-out in the MSB.
- `busy` out 1: high in RUN and DRAIN.
- `done` out 1: high in DONE.
- `pass` out 1: high when `done` is high and `err_count`==0.
- `vec_count` out CNT_W: vectors checked.
- `err_count` out CNT_W: mismatches; saturates at all-ones.
- `first_err_idx` out CNT_W: index of the first mismatching vector.
- `first_err_exp` out WIDTH+1: expected sum of the first mismatch.
- `first_err_got` out WIDTH+1: received sum of the first mismatch.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE→RUN when `start` is high.
  - RUN→DRAIN after vector NUM_VECTORS-1 is launched.
  - DRAIN→DONE at the check of the last vector.
  - DONE→RUN when `start` is high.
  - `start` is ignored in RUN and DRAIN.
- On entry to RUN: reload both LFSRs from their seeds, and clear all counters and first-error fields. Every run is therefore reproducible.
- LFSRs: Galois, 32-bit, taps 32,22,2,1, advancing once per launched vector. The operand is the low WIDTH bits of the state.
- Golden sum: `{1'b0,op_a} + {1'b0,op_b}`, WIDTH+1 bits, with no truncation.
- Golden sum and valid flag travel through a LATENCY+1 deep shift register. A valid flag at the tail triggers the compare.
- On mismatch: increment `err_count` (saturating). If it was 0, capture index, expected and received values. Later mismatches never overwrite the captured record.
- `vec_count` increments on every compare.
- `op_a`/`op_b` hold the last vector through DRAIN and DONE.
- Reset values: `op_a`/`op_b`=0, `busy`/`done`/`pass`=0, all counters and first-error fields 0, FSM in IDLE, LFSRs at their seeds.
- `rst` during RUN or DRAIN aborts the run immediately: the pipeline valids are cleared and no partial counts are kept.

## Timing
- E0 is the edge where `start` is sampled. Vector i is on `op_a`/`op_b` from edge E0+i.
- `dut_sum` for vector i is sampled at edge E0+i+1+LATENCY.
- Counters update at the sampling edge.
- The last compare is at edge E0+NUM_VECTORS+LATENCY. At that same edge `done` rises, `busy` falls, and `pass` becomes valid.
- Throughput is one vector per cycle, with no bubbles.

## Configuration
- `ADD_CHK_CORNER_EN`, when defined: vectors 0..3 are fixed corner cases. With all-ones written as M:
  - 0+0
  - M+1
  - M+M
  - alternating 1010…+0101…
- With the macro defined, the LFSRs first advance at vector 4. The corner vectors count toward NUM_VECTORS.
- Undefined: all vectors come from the LFSRs, starting at vector 0.

## Structure
- Package `add_chk_pkg`:
  - FSM state enum;
  - LFSR tap mask constant;
  - corner-vector generator function of WIDTH.
- Sub-module `lfsr32`: seed load, advance enable, 32-bit state out. It is instantiated twice, for A and B.
- The pipeline, comparator, counters and FSM all live in the top module.

## Test plan
- NUM_VECTORS=8, LATENCY=1, ideal registered-adder model:
  - `done` rises 9 edges after E0;
  - `vec_count`=8, `err_count`=0, `pass`=1.
- Same setup with bit 3 of `dut_sum` forced to 0:
  - `err_count`>0 and `pass`=0;
  - `first_err_idx` is the first vector whose true sum has bit 3 set;
  - `first_err_got` equals `first_err_exp` with bit 3 cleared.
- `ADD_CHK_CORNER_EN` defined, WIDTH=16:
  - vectors 0..3 are 0000+0000, FFFF+0001, FFFF+FFFF, AAAA+5555;
  - expected sums are 0x00000, 0x10000, 0x1FFFE, 0x0FFFF;
  - ideal model gives `pass`=1.
- `rst` pulsed during RUN at vector 5:
  - next cycle: `busy`=0, all counters 0;
  - a subsequent `start` reproduces the identical operand sequence from vector 0.
- `start` held high throughout RUN: no restart, final `vec_count`=NUM_VECTORS. `start` pulsed in DONE: counters clear and a new run begins at E0.
- LATENCY=3 with a 3-stage delayed model gives `pass`=1. The same model with LATENCY=2 gives `err_count` > 0.
